// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: drives register enables/clears
// for load-use, redirect, mul/div occupancy and memory wait, and counts stall cycles.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 8,
    parameter int RA_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs_i,
    input  logic [RA_W-1:0] id_rt_i,
    input  logic            id_uses_rs_i,
    input  logic            id_uses_rt_i,
    input  logic [RA_W-1:0] ex_rd_i,
    input  logic            ex_memtoreg_i,
    input  logic            ex_regwrite_i,
    input  logic            ex_redirect_i,
    input  logic            id_md_start_i,
    input  logic            mem_req_i,
    input  logic            mem_ack_i,
    output logic            pc_en_o,
    output logic            ifid_en_o,
    output logic            ifid_clear_o,
    output logic            idex_en_o,
    output logic            idex_clear_o,
    output logic            exmem_en_o,
    output logic            exmem_clear_o,
    output logic            memwb_en_o,
    output logic            md_busy_o,
    output logic [31:0]     stall_cycles_o,
    output logic [1:0]      state_dbg_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] MD_INIT = 8'(MD_LAT - 1);

    state_t      state_q, state_d;
    state_t      ret_state_q, ret_state_d;
    logic [7:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_q, stall_d;

    logic   mem_freeze;
    logic   load_use;
    state_t eff_state;

    assign mem_freeze = mem_req_i & ~mem_ack_i;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_memtoreg_i & ex_regwrite_i & (ex_rd_i != '0) &
                      ((id_uses_rs_i & (id_rs_i == ex_rd_i)) |
                       (id_uses_rt_i & (id_rt_i == ex_rd_i)));

    // Once the memory stall releases, behave as the state we were frozen in.
    assign eff_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        ifid_clear_o  = 1'b0;
        idex_en_o     = 1'b1;
        idex_clear_o  = 1'b0;
        exmem_en_o    = 1'b1;
        exmem_clear_o = 1'b0;
        memwb_en_o    = 1'b1;
        if (!rst) begin
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
            memwb_en_o = 1'b0;
        end else if (mem_freeze) begin
            pc_en_o    = 1'b0;
            ifid_en_o  = 1'b0;
            idex_en_o  = 1'b0;
            exmem_en_o = 1'b0;
            memwb_en_o = 1'b0;
        end else if (eff_state == MD_BUSY) begin
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_clear_o = 1'b1;
        end else if (ex_redirect_i) begin
            ifid_clear_o = 1'b1;
            idex_clear_o = 1'b1;
        end else if (load_use) begin
            pc_en_o      = 1'b0;
            ifid_en_o    = 1'b0;
            idex_clear_o = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        md_cnt_d    = md_cnt_q;
        if (mem_freeze) begin
            if (state_q != MEM_WAIT) begin
                ret_state_d = state_q;
                state_d     = MEM_WAIT;
            end
        end else if (eff_state == MD_BUSY) begin
            if (md_cnt_q <= 8'd1) begin
                state_d  = RUN;
                md_cnt_d = 8'd0;
            end else begin
                state_d  = MD_BUSY;
                md_cnt_d = md_cnt_q - 8'd1;
            end
        end else begin
            state_d = RUN;
            if (!ex_redirect_i && !load_use && id_md_start_i) begin
                state_d  = MD_BUSY;
                md_cnt_d = MD_INIT;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_en_o && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            md_cnt_q    <= 8'd0;
            stall_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            md_cnt_q    <= md_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign md_busy_o      = (state_q == MD_BUSY) ||
                            ((state_q == MEM_WAIT) && (ret_state_q == MD_BUSY));
    assign stall_cycles_o = stall_q;
    assign state_dbg_o    = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard/stall controller for the 5-stage MIPS pipeline. Drives the load-enable and clear inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, taken-branch/jump redirects, multi-cycle mul/div occupancy and data-memory wait states, and it counts stall cycles.
Enable outputs use the pipeline-register convention: 1 = load new value, 0 = hold. Clear (1 = bubble) overrides enable at the receiving register.

Parameters:
MD_LAT, 8, mul/div unit latency in cycles (range 2..255)
RA_W, 5, register-address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
id_rs  in  RA_W  rs field of the instruction in ID
id_rt  in  RA_W  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_rd  in  RA_W  destination register of the instruction in EX
ex_memtoreg  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes a register
ex_redirect  in  1  branch taken / jump resolved in EX this cycle
id_md_start  in  1  ID instruction is mul/div and will issue to EX
mem_req  in  1  MEM stage has a valid load/store
mem_ack  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_clear  out  1  IF/ID flush
idex_en  out  1  ID/EX load enable
idex_clear  out  1  ID/EX flush (bubble)
exmem_en  out  1  EX/MEM load enable
exmem_clear  out  1  EX/MEM bubble
memwb_en  out  1  MEM/WB load enable
md_busy  out  1  mul/div occupancy
stall_cycles  out  32  count of cycles with pc_en=0, saturating

Behaviour:
- Reset: clk and rst as decided (rst asynchronous, active-low; clk rising edge). While rst=0:
  - state=RUN, ret_state=RUN, md_cnt=0, stall_cycles=0.
  - All *_en and *_clear outputs are 0 (combinationally gated by rst), and md_busy=0.
- Reset mid-operation aborts any MD_BUSY or MEM_WAIT immediately, with no residual stall.
- States:
  - RUN: normal flow.
  - MD_BUSY: mul/div in EX.
  - MEM_WAIT: memory freeze. A ret_state register holds RUN or MD_BUSY for the return.
- Outputs are combinational from state and inputs, so there is zero-cycle latency. Defaults are all en=1 and all clears=0.
- Priority, highest first:
  - P1 memory wait: applies in any state when mem_req=1 and mem_ack=0.
    - Outputs: all five enables 0 and all clears 0 (full freeze).
    - Transition: on entry, ret_state<=state and state<=MEM_WAIT.
    - In MEM_WAIT the freeze holds until mem_ack=1. In the ack cycle, outputs are those of ret_state evaluated normally (P2..P5), and state<=ret_state.
    - md_cnt does not decrement during the freeze.
  - P2 MD_BUSY:
    - Outputs: pc_en=ifid_en=idex_en=0, exmem_clear=1, memwb_en=1. ex_redirect and the load-use check are ignored.
    - md_cnt decrements each cycle. When md_cnt==1, the next cycle is RUN with md_cnt=0.
    - Total front-end hold is MD_LAT-1 cycles.
  - P3 redirect: in RUN with ex_redirect=1, ifid_clear=1 and idex_clear=1; pc_en=1. id_md_start and load-use are ignored because the ID instruction is squashed.
  - P4 load-use: in RUN with ex_memtoreg & ex_regwrite & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
    - Outputs: pc_en=0, ifid_en=0, idex_clear=1, for exactly one cycle.
    - The re-check in the next cycle sees the load in MEM, so there is no repeat.
  - P5 mul/div issue: in RUN with id_md_start=1 and no P3/P4.
    - The instruction advances normally this cycle.
    - Transition: state<=MD_BUSY, md_cnt<=MD_LAT-1.
- md_busy=1 exactly when state==MD_BUSY, or state==MEM_WAIT with ret_state==MD_BUSY.
- rs/rt == 0 never produces a load-use stall.
- stall_cycles increments on every clk edge where pc_en==0 and rst=1. It holds at 32'hFFFF_FFFF when saturated.
- The clear signals are never asserted together with a full freeze.

Test Plan:
1. Release rst after 3 cycles with all inputs 0 -> during reset all en/clear=0, stall_cycles=0; first cycle after release: all en=1, clears=0.
2. Load r5 in EX (ex_memtoreg=1, ex_regwrite=1, ex_rd=5); ID id_rs=5, id_uses_rs=1 -> one cycle of pc_en=0, ifid_en=0, idex_clear=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
3. Same load-use plus ex_redirect=1 -> ifid_clear=1, idex_clear=1, pc_en=1; no stall; stall_cycles unchanged.
4. MD_LAT=8, id_md_start=1 in RUN -> next 7 cycles: md_busy=1, pc_en=ifid_en=idex_en=0, exmem_clear=1; 8th cycle RUN; stall_cycles=7.
5. MD issue, then mem_req=1/mem_ack=0 for 3 cycles after 2 busy cycles -> all en=0 for 3 cycles, md_busy stays 1. After ack, 5 further busy cycles then RUN; stall_cycles=10.
6. Assert rst mid-MD_BUSY (md_cnt=4) -> outputs drop to 0 immediately. After release: state RUN, md_busy=0, all en=1, stall_cycles=0.
